// File: rtl/freq_meter_ar_if.sv
// freq_meter_ar_if: measurement/display bus of the auto-ranging frequency meter.
// master = measurement source / consumer side, slave = freq_meter_ar core.
`timescale 1ns/1ps

interface freq_meter_ar_if #(
  parameter int DIGITS = 4
) ();
  logic                  sigin;
  logic [1:0]            modecontrol;
  logic                  hold;
  logic [4*DIGITS-1:0]   result;
  logic [1:0]            range;
  logic                  highfreq;
  logic                  overflow;
  logic                  valid;
  logic [6:0]            cathodes;
  logic [DIGITS-1:0]     an;

  modport master (
    output sigin, modecontrol, hold,
    input  result, range, highfreq, overflow, valid, cathodes, an
  );

  modport slave (
    input  sigin, modecontrol, hold,
    output result, range, highfreq, overflow, valid, cathodes, an
  );
endinterface

// File: rtl/freq_meter_ar.sv
// freq_meter_ar: auto-ranging BCD frequency meter with multiplexed 7-segment output.
// Optional feature macro: FM_AUTORANGE_EN. Defined: the gate range steps by decades
// on overflow/underflow and modecontrol is ignored. Undefined (default): the range
// is loaded from the clamped modecontrol input at every terminal cycle.
`timescale 1ns/1ps

module freq_meter_ar #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGITS   = 4,
  parameter int NRANGES  = 3,
  parameter int SCAN_DIV = 100_000
) (
  input logic           sysclk,
  input logic           rst,
  freq_meter_ar_if.slave bus
);

  localparam int GW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  localparam logic [GW-1:0] GATE_LAST0 = GW'(CLK_HZ - 1);
  localparam logic [GW-1:0] GATE_LAST1 = GW'(CLK_HZ / 10 - 1);
  localparam logic [GW-1:0] GATE_LAST2 = GW'(CLK_HZ / 100 - 1);
  localparam logic [GW-1:0] GATE_LAST3 = GW'(CLK_HZ / 1000 - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [1:0]    RMAX       = 2'(NRANGES - 1);
  localparam logic [BW-1:0] BCD_ALL9   = {DIGITS{4'h9}};
  localparam logic [BW-1:0] BCD_ONE    = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [DIGITS-1:0] AN_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  // Last gate-counter value of the window for decade range r.
  function automatic logic [GW-1:0] gate_last(input logic [1:0] r);
    case (r)
      2'd0:    gate_last = GATE_LAST0;
      2'd1:    gate_last = GATE_LAST1;
      2'd2:    gate_last = GATE_LAST2;
      default: gate_last = GATE_LAST3;
    endcase
  endfunction

  // BCD increment of a non-saturated cascade (ripple carry through 9s).
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] o;
    logic          c;
    o = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          o[4*i +: 4] = 4'd0;
        end else begin
          o[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        o[4*i +: 4] = v[4*i +: 4];
      end
    end
    return o;
  endfunction

  // Active-low segment pattern (bit0=a .. bit6=g); codes A-F blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic              sync1_r, sync2_r, sync3_r;
  logic              rise_s;
  logic [GW-1:0]     gate_r;
  logic              terminal_s;
  logic [BW-1:0]     bcd_r;
  logic              wovf_r;
  logic [1:0]        range_r;
  logic [1:0]        range_nxt_s;
  logic [BW-1:0]     result_r;
  logic [1:0]        pub_range_r;
  logic              highfreq_r;
  logic              overflow_r;
  logic              valid_r;
  logic [SW-1:0]     scan_r;
  logic              scan_wrap_s;
  logic [IW-1:0]     idx_r;
  logic [IW-1:0]     idx_nxt_s;
  logic [3:0]        digit_s;
  logic [DIGITS-1:0] an_nxt_s;
  logic [DIGITS-1:0] an_r;
  logic [6:0]        cathodes_r;

  assign rise_s      = sync2_r & ~sync3_r;
  assign terminal_s  = (gate_r == gate_last(range_r));
  assign scan_wrap_s = (scan_r == SCAN_LAST);

  // Two-flop synchroniser for sigin plus a delayed copy for rising-edge detection.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= bus.sigin;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Gate window counter; restarts after the terminal cycle of the current range.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      gate_r <= '0;
    end else if (terminal_s) begin
      gate_r <= '0;
    end else begin
      gate_r <= gate_r + GW'(1);
    end
  end

  // BCD edge counter with sticky saturation; a terminal-cycle edge seeds the next window.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      bcd_r  <= '0;
      wovf_r <= 1'b0;
    end else if (terminal_s) begin
      bcd_r  <= rise_s ? BCD_ONE : '0;
      wovf_r <= 1'b0;
    end else if (rise_s) begin
      if (bcd_r == BCD_ALL9) begin
        wovf_r <= 1'b1;
      end else begin
        bcd_r <= bcd_inc(bcd_r);
      end
    end
  end

  // Range for the next window: decade stepping or clamped manual selection.
  always_comb begin
    range_nxt_s = range_r;
`ifdef FM_AUTORANGE_EN
    if (wovf_r && (range_r < RMAX)) begin
      range_nxt_s = range_r + 2'd1;
    end else if (!wovf_r && (bcd_r[BW-1 -: 4] == 4'd0) && (range_r != 2'd0)) begin
      range_nxt_s = range_r - 2'd1;
    end else begin
      range_nxt_s = range_r;
    end
`else
    if (bus.modecontrol > RMAX) begin
      range_nxt_s = RMAX;
    end else begin
      range_nxt_s = bus.modecontrol;
    end
`endif
  end

  // Active range register; keeps adapting even while published outputs are held.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      range_r <= 2'd0;
    end else if (terminal_s) begin
      range_r <= range_nxt_s;
    end
  end

  // Publish the finished window unless hold is set; valid marks the update cycle.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      result_r    <= '0;
      pub_range_r <= 2'd0;
      highfreq_r  <= 1'b0;
      overflow_r  <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      valid_r <= terminal_s & ~bus.hold;
      if (terminal_s && !bus.hold) begin
        result_r    <= bcd_r;
        pub_range_r <= range_r;
        highfreq_r  <= (range_r != 2'd0);
        overflow_r  <= wovf_r;
      end
    end
  end

  // Next digit index and its anode pattern / BCD digit for the following scan step.
  always_comb begin
    idx_nxt_s = (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    digit_s   = 4'h0;
    an_nxt_s  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_nxt_s) begin
        digit_s     = result_r[4*i +: 4];
        an_nxt_s[i] = 1'b0;
      end else begin
        an_nxt_s[i] = 1'b1;
      end
    end
  end

  // Free-running scan prescaler; digit, anodes and segments change only on its wrap.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      scan_r     <= '0;
      idx_r      <= '0;
      an_r       <= AN_RST;
      cathodes_r <= 7'b1000000;
    end else if (scan_wrap_s) begin
      scan_r     <= '0;
      idx_r      <= idx_nxt_s;
      an_r       <= an_nxt_s;
      cathodes_r <= seg_decode(digit_s);
    end else begin
      scan_r <= scan_r + SW'(1);
    end
  end

  assign bus.result   = result_r;
  assign bus.range    = pub_range_r;
  assign bus.highfreq = highfreq_r;
  assign bus.overflow = overflow_r;
  assign bus.valid    = valid_r;
  assign bus.an       = an_r;
  assign bus.cathodes = cathodes_r;

endmodule

// File: tb/tb_freq_meter_ar.sv
// tb_freq_meter_ar: directed self-checking bench for freq_meter_ar
// (CLK_HZ=1000, DIGITS=2, NRANGES=3, SCAN_DIV=4; gates 1000/100/10 cycles).
`timescale 1ns/1ps

module tb_freq_meter_ar;

  localparam int CLK_HZ   = 1000;
  localparam int DIGITS   = 2;
  localparam int NRANGES  = 3;
  localparam int SCAN_DIV = 4;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;

  int n_checks  = 0;
  int n_fail    = 0;
  int half      = 10;   // periodic sigin half-period in cycles, 0 = off
  int pulse_req = 0;    // exact pulses requested by the test sequence
  int pulse_done = 0;   // exact pulses emitted by the generator

  freq_meter_ar_if #(.DIGITS(DIGITS)) bus ();

  freq_meter_ar #(
    .CLK_HZ(CLK_HZ), .DIGITS(DIGITS), .NRANGES(NRANGES), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 sysclk = ~sysclk;

  // sigin generator: exact 2-high/2-low pulses on request, else periodic square wave.
  initial begin
    bus.sigin = 1'b0;
    forever begin
      if (pulse_done != pulse_req) begin
        bus.sigin = 1'b1;
        repeat (2) @(negedge sysclk);
        bus.sigin = 1'b0;
        repeat (2) @(negedge sysclk);
        pulse_done++;
      end else if (half > 0) begin
        bus.sigin = 1'b1;
        repeat (half) @(negedge sysclk);
        bus.sigin = 1'b0;
        repeat (half) @(negedge sysclk);
      end else begin
        @(negedge sysclk);
      end
    end
  end

  // Wait (bounded) for the next valid pulse, sampling on falling edges.
  task automatic wait_valid(input int max_cycles, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max_cycles) begin
      @(negedge sysclk);
      n++;
      if (bus.valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok; int n;
    rst = 1'b1; half = 10;
    repeat (5) @(negedge sysclk);
    rst = 1'b0;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL first_valid_timeout: waited %0d cycles", n); end
    n_checks++; if (n != 1000) begin n_fail++; $display("FAIL first_valid_latency: got %0d expected 1000", n); end
    n_checks++; if (!(bus.result inside {8'h49, 8'h50, 8'h51})) begin n_fail++; $display("FAIL first_result: got %h expected 50+-1", bus.result); end
    repeat (300) @(negedge sysclk);
    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL rst_result: got %h expected 00", bus.result); end
    n_checks++; if (bus.range !== 2'd0) begin n_fail++; $display("FAIL rst_range: got %0d expected 0", bus.range); end
    n_checks++; if (bus.valid !== 1'b0 || bus.highfreq !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags: got v%b h%b o%b expected 000", bus.valid, bus.highfreq, bus.overflow); end
    n_checks++; if (bus.an !== 2'b10) begin n_fail++; $display("FAIL rst_an: got %b expected 10", bus.an); end
    n_checks++; if (bus.cathodes !== 7'b1000000) begin n_fail++; $display("FAIL rst_cathodes: got %b expected 1000000", bus.cathodes); end
    @(negedge sysclk);
    rst = 1'b0;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 1000) begin n_fail++; $display("FAIL post_rst_latency: got %0d (ok=%0b) expected 1000", n, ok); end
    n_checks++; if (!(bus.result inside {8'h49, 8'h50, 8'h51})) begin n_fail++; $display("FAIL post_rst_result: got %h expected 50+-1", bus.result); end
  endtask

`ifdef FM_AUTORANGE_EN
  task automatic test_autorange();
    bit ok; int n;
    rst = 1'b1; half = 2;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 1000) begin n_fail++; $display("FAIL up_period: got %0d expected 1000", n); end
    n_checks++; if (bus.result !== 8'h99 || bus.overflow !== 1'b1 || bus.range !== 2'd0) begin
      n_fail++; $display("FAIL up_sat: got r=%h o=%b rg=%0d expected 99/1/0", bus.result, bus.overflow, bus.range); end
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 100) begin n_fail++; $display("FAIL up_gate1: got %0d expected 100", n); end
    n_checks++; if (bus.result !== 8'h25 || bus.range !== 2'd1) begin
      n_fail++; $display("FAIL up_result: got r=%h rg=%0d expected 25/1", bus.result, bus.range); end
    n_checks++; if (bus.highfreq !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL up_flags: got h%b o%b expected h1 o0", bus.highfreq, bus.overflow); end
    half = 50;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 100) begin n_fail++; $display("FAIL down_gate1: got %0d expected 100", n); end
    n_checks++; if (!(bus.result inside {8'h01, 8'h02}) || bus.range !== 2'd1) begin
      n_fail++; $display("FAIL down_low: got r=%h rg=%0d expected 01/1", bus.result, bus.range); end
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 1000) begin n_fail++; $display("FAIL down_gate0: got %0d expected 1000", n); end
    n_checks++; if (bus.result !== 8'h10 || bus.range !== 2'd0 || bus.highfreq !== 1'b0) begin
      n_fail++; $display("FAIL down_result: got r=%h rg=%0d h%b expected 10/0/0", bus.result, bus.range, bus.highfreq); end
    half = 10;
  endtask
`else
  task automatic test_manual();
    bit ok; int n;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 1000) begin n_fail++; $display("FAIL man_period: got %0d expected 1000", n); end
    n_checks++; if (!(bus.result inside {8'h49, 8'h50, 8'h51}) || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL man_result: got r=%h o=%b expected 50+-1/0", bus.result, bus.overflow); end
    n_checks++; if (bus.range !== 2'd0 || bus.highfreq !== 1'b0) begin
      n_fail++; $display("FAIL man_range0: got rg=%0d h%b expected 0/0", bus.range, bus.highfreq); end
    bus.modecontrol = 2'd3;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 1000 || bus.range !== 2'd0) begin
      n_fail++; $display("FAIL clamp_pending: got n=%0d rg=%0d expected 1000/0", n, bus.range); end
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 10) begin n_fail++; $display("FAIL clamp_gate: got %0d expected 10", n); end
    n_checks++; if (bus.range !== 2'd2 || bus.highfreq !== 1'b1) begin
      n_fail++; $display("FAIL clamp_range: got rg=%0d h%b expected 2/1", bus.range, bus.highfreq); end
    bus.modecontrol = 2'd0;
    half = 2;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 10 || bus.range !== 2'd2) begin
      n_fail++; $display("FAIL back_pending: got n=%0d rg=%0d expected 10/2", n, bus.range); end
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 1000) begin n_fail++; $display("FAIL sat_period: got %0d expected 1000", n); end
    n_checks++; if (bus.result !== 8'h99 || bus.overflow !== 1'b1 || bus.range !== 2'd0) begin
      n_fail++; $display("FAIL sat_result: got r=%h o=%b rg=%0d expected 99/1/0", bus.result, bus.overflow, bus.range); end
    half = 10;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || bus.overflow !== 1'b0 || !(bus.result inside {8'h49, 8'h50, 8'h51})) begin
      n_fail++; $display("FAIL ovf_clear: got r=%h o=%b expected 50+-1/0", bus.result, bus.overflow); end
  endtask
`endif

  // Checks the scan on result 0x37; returns the number of cycles it consumed.
  task automatic test_display(output int used);
    logic [1:0] prev_an;
    int run, changes, bad_seg, bad_run;
    repeat (8) @(negedge sysclk);
    prev_an = bus.an; run = 0; changes = 0; bad_seg = 0; bad_run = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge sysclk);
      if (bus.an === 2'b10) begin
        if (bus.cathodes !== 7'b1111000) bad_seg++;
      end else if (bus.an === 2'b01) begin
        if (bus.cathodes !== 7'b0110000) bad_seg++;
      end else begin
        bad_seg++;
      end
      if (bus.an !== prev_an) begin
        if (changes > 0 && run != 4) bad_run++;
        if (bus.an !== ~prev_an) bad_run++;
        changes++;
        run = 1;
      end else begin
        run++;
      end
      prev_an = bus.an;
    end
    n_checks++; if (bad_seg != 0) begin n_fail++; $display("FAIL disp_segments: got %0d bad samples expected 0", bad_seg); end
    n_checks++; if (bad_run != 0 || changes < 5) begin
      n_fail++; $display("FAIL disp_scan: got %0d bad steps, %0d changes expected 0 bad, >=5 changes", bad_run, changes); end
    used = 32;
  endtask

  task automatic test_hold();
    bit ok; int n, used, bad;
    half = 0;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_sync_timeout: waited %0d cycles", n); end
    pulse_req = pulse_req + 37;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 1000) begin n_fail++; $display("FAIL exact_period: got %0d expected 1000", n); end
    n_checks++; if (bus.result !== 8'h37 || bus.overflow !== 1'b0 || bus.range !== 2'd0) begin
      n_fail++; $display("FAIL exact_result: got r=%h o=%b rg=%0d expected 37/0/0", bus.result, bus.overflow, bus.range); end
    bus.hold = 1'b1;
    pulse_req = pulse_req + 5;
    test_display(used);
    bad = 0;
    for (int i = used; i < 2100; i++) begin
      @(negedge sysclk);
      if (bus.valid !== 1'b0 || bus.result !== 8'h37) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_frozen: got %0d changed samples expected 0", bad); end
    bus.hold = 1'b0;
    pulse_req = pulse_req + 21;
    wait_valid(1100, ok, n);
    n_checks++; if (!ok || n != 900) begin n_fail++; $display("FAIL release_latency: got %0d expected 900", n); end
    n_checks++; if (bus.result !== 8'h21) begin n_fail++; $display("FAIL release_result: got %h expected 21", bus.result); end
  endtask

  initial begin
    bus.hold = 1'b0;
    bus.modecontrol = 2'd0;
    test_reset();
`ifdef FM_AUTORANGE_EN
    test_autorange();
`else
    test_manual();
`endif
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
